// File: rtl/float_pkg.sv
// Shared definitions for the float accumulator slice: mantissa/exponent
// widths, the sample counter width and the controller state encoding.
package float_pkg;

    localparam int MANT_W  = 4;
    localparam int EXP_W   = 2;
    localparam int SHCNT_W = 2;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A sample F with exponent P represents F >> (3 - P).
    function automatic logic [SHCNT_W-1:0] shift_amount(input logic [EXP_W-1:0] p);
        return SHCNT_W'(2'd3 - p);
    endfunction

endpackage

// File: rtl/float_accumulator_if.sv
// Sample/result bundle of the float accumulator. The master side supplies
// samples and the abort, the slave side (the accumulator) returns the sums.
interface float_accumulator_if
    import float_pkg::*;
#(
    parameter int SUM_W = 6
) ();

    logic              clr;
    logic [MANT_W-1:0] F;
    logic [EXP_W-1:0]  P;
    logic              in_valid;
    logic              in_ready;
    logic [SUM_W-1:0]  sum;
    logic              out_valid;
    logic              ovf;

    modport master (
        output clr, F, P, in_valid,
        input  in_ready, sum, out_valid, ovf
    );

    modport slave (
        input  clr, F, P, in_valid,
        output in_ready, sum, out_valid, ovf
    );

endinterface

// File: rtl/float_denorm.sv
// Serial right-shifter that turns a (mantissa, exponent) pair into its
// fixed-point value, one bit position per clock while run is high.
module float_denorm
    import float_pkg::*;
(
    input  logic               sysClk,
    input  logic               sysRst,
    input  logic               clr,
    input  logic               load,
    input  logic               run,
    input  logic [MANT_W-1:0]  load_mant,
    input  logic [SHCNT_W-1:0] load_shift,
    output logic [MANT_W-1:0]  mant,
    output logic               busy,
    output logic               done
);

    logic [MANT_W-1:0]  shift_buf;
    logic [SHCNT_W-1:0] shcnt;

    // Load a new mantissa, or shift it right (zero fill) until the count runs out.
    always_ff @(posedge sysClk or negedge sysRst) begin
        if (!sysRst) begin
            shift_buf <= '0;
            shcnt     <= '0;
        end else if (clr) begin
            shift_buf <= '0;
            shcnt     <= '0;
        end else if (load) begin
            shift_buf <= load_mant;
            shcnt     <= load_shift;
        end else if (run && (shcnt != '0)) begin
            shift_buf <= shift_buf >> 1;
            shcnt     <= shcnt - SHCNT_W'(1);
        end
    end

    assign mant = shift_buf;
    assign busy = (shcnt != '0);
    assign done = run && (shcnt == '0);

endmodule

// File: rtl/float_accumulator.sv
// Block accumulator for denormalised float samples: each accepted sample is
// shifted into fixed point, added into acc, and every ACC_LEN samples the
// total is published on sum with a one-cycle out_valid pulse.
// Build option FLOAT_ACC_SAT_EN: saturate acc at all-ones on overflow
// instead of wrapping; ovf behaves the same either way.
module float_accumulator
    import float_pkg::*;
#(
    parameter int SUM_W   = 6,
    parameter int ACC_LEN = 8
) (
    input  logic sysClk,
    input  logic sysRst,
    float_accumulator_if.slave bus
);

    state_t             state;
    state_t             state_next;
    logic [SUM_W-1:0]   acc;
    logic [SUM_W-1:0]   sum_q;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_q;
    logic               out_valid_q;

    logic               in_ready;
    logic               accept;
    logic               add_en;
    logic               finish;
    logic               last_sample;

    logic [MANT_W-1:0]  mant;
    logic               busy;
    logic               done;
    logic               shifting;

    logic [SUM_W:0]     sum_wide;
    logic               carry;
    logic [SUM_W-1:0]   acc_added;

    assign accept      = bus.in_valid && in_ready;
    assign shifting    = (state == SHIFT);
    assign last_sample = (cnt == CNT_W'(ACC_LEN - 1));

    float_denorm u_denorm (
        .sysClk     (sysClk),
        .sysRst     (sysRst),
        .clr        (bus.clr),
        .load       (accept),
        .run        (shifting),
        .load_mant  (bus.F),
        .load_shift (shift_amount(bus.P)),
        .mant       (mant),
        .busy       (busy),
        .done       (done)
    );

    // One extra carry bit tells us when the add runs past SUM_W bits.
    assign sum_wide = {1'b0, acc} + (SUM_W + 1)'(mant);
    assign carry    = sum_wide[SUM_W];

`ifdef FLOAT_ACC_SAT_EN
    assign acc_added = carry ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
`else
    assign acc_added = sum_wide[SUM_W-1:0];
`endif

    // Controller state register.
    always_ff @(posedge sysClk or negedge sysRst) begin
        if (!sysRst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: one sample in flight at a time; an abort always wins.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (!busy)  state_next = last_sample ? DONE : IDLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.clr) begin
            state_next = IDLE;
        end
    end

    // Controller outputs; the abort masks every action of the current cycle.
    always_comb begin
        in_ready = (state == IDLE) && !bus.clr;
        add_en   = done && !bus.clr;
        finish   = (state == DONE) && !bus.clr;
    end

    // Accumulator, sample count, overflow flag and published result. The
    // overflow flag stays up through the out_valid cycle so it is seen
    // alongside the sum it belongs to, then drops for the next block.
    always_ff @(posedge sysClk or negedge sysRst) begin
        if (!sysRst) begin
            acc         <= '0;
            cnt         <= '0;
            ovf_q       <= 1'b0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.clr) begin
            acc         <= '0;
            cnt         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= finish;
            if (finish) begin
                sum_q <= acc;
                acc   <= '0;
                cnt   <= '0;
            end else if (add_en) begin
                acc <= acc_added;
                cnt <= cnt + CNT_W'(1);
            end
            if (add_en && carry) begin
                ovf_q <= 1'b1;
            end else if (out_valid_q) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.sum       = sum_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_float_accumulator.sv
// Self-checking bench for float_accumulator: a single-sample instance
// (ACC_LEN=1) is driven from a vector table for value/latency, the default
// instance runs hand-written block sequences and a randomized run against a
// block-sum reference model.
module tb_float_accumulator;

    localparam int SUM_W = 6;
    localparam int LIM   = (1 << SUM_W) - 1;
`ifdef FLOAT_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [SUM_W-1:0] s;
        logic             o;
    } obs_t;

    typedef struct {
        logic [3:0] f;
        logic [1:0] p;
        int         exp_sum;
        int         exp_lat;
    } vec_t;

    typedef struct {
        logic [3:0] f;
        logic [1:0] p;
    } smp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    obs_t obs_q[$];
    obs_t exp_q[$];
    logic prev_ov;

    float_accumulator_if #(.SUM_W(SUM_W)) bus_a ();
    float_accumulator_if #(.SUM_W(SUM_W)) bus_b ();

    float_accumulator #(.SUM_W(SUM_W), .ACC_LEN(8)) dut_a (
        .sysClk (clk),
        .sysRst (rst_n),
        .bus    (bus_a)
    );

    float_accumulator #(.SUM_W(SUM_W), .ACC_LEN(1)) dut_b (
        .sysClk (clk),
        .sysRst (rst_n),
        .bus    (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    // Expected published result for a block whose true arithmetic total is t.
    function automatic obs_t model_block(input int t);
        obs_t e;
        if (SAT) e.s = (t > LIM) ? SUM_W'(LIM) : SUM_W'(t);
        else     e.s = SUM_W'(t % (LIM + 1));
        e.o = (t > LIM);
        return e;
    endfunction

    // Record every result pulse of the default instance; pulses must not touch.
    always @(negedge clk) begin
        if (bus_a.out_valid === 1'b1) begin
            checkOutput("out_valid_gap", {31'd0, prev_ov}, 0);
            obs_q.push_back({bus_a.sum, bus_a.ovf});
        end
        prev_ov = bus_a.out_valid;
    end

    // Offer one sample to the default instance; returns just after the accept edge.
    task automatic applyStimulus(input logic [3:0] f, input logic [1:0] p);
        logic got;
        got = 1'b0;
        bus_a.F = f;
        bus_a.P = p;
        bus_a.in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            got = bus_a.in_ready;
            if (got) break;
            @(posedge clk);
            #1;
        end
        checkOutput("accept", {31'd0, got}, 1);
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
    endtask

    // Send one sample and report how many cycles in_ready stayed low after it.
    task automatic send_a(input logic [3:0] f, input logic [1:0] p, output int low);
        applyStimulus(f, p);
        low = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_a.in_ready) break;
            low++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic block_a(input logic [3:0] f, input logic [1:0] p, input int n);
        int low;
        for (int i = 0; i < n; i++) send_a(f, p, low);
    endtask

    task automatic wait_obs(input string name, input int want_sum, input int want_ovf);
        obs_t e;
        e = '0;
        for (int k = 0; k < 40 && obs_q.size() == 0; k++) @(negedge clk);
        checkOutput({name, "_seen"}, obs_q.size() > 0, 1);
        if (obs_q.size() > 0) begin
            e = obs_q.pop_front();
            checkOutput({name, "_sum"}, e.s, want_sum);
            checkOutput({name, "_ovf"}, e.o, want_ovf);
        end
    endtask

    initial begin
        vec_t vecs[10];
        smp_t mix[8];
        int   low;
        int   lat;
        int   accepts;
        int   cnt_m;
        int   sum_m;
        logic do_clr;

        vecs[0] = '{4'b1000, 2'd0, 1,  5};
        vecs[1] = '{4'b1000, 2'd3, 8,  2};
        vecs[2] = '{4'b1111, 2'd3, 15, 2};
        vecs[3] = '{4'b1010, 2'd2, 5,  3};
        vecs[4] = '{4'b1100, 2'd1, 3,  4};
        vecs[5] = '{4'b1110, 2'd0, 1,  5};
        vecs[6] = '{4'b0000, 2'd2, 0,  3};
        vecs[7] = '{4'b0110, 2'd1, 1,  4};
        vecs[8] = '{4'b0111, 2'd3, 7,  2};
        vecs[9] = '{4'b1001, 2'd2, 4,  3};

        mix[0] = '{4'b1010, 2'd2};
        mix[1] = '{4'b1100, 2'd1};
        mix[2] = '{4'b1000, 2'd3};
        for (int i = 3; i < 8; i++) mix[i] = '{4'b0000, 2'd0};

        total = 0;
        bad = 0;
        prev_ov = 1'b0;
        rst_n = 1'b1;
        bus_a.clr = 1'b0; bus_a.in_valid = 1'b0; bus_a.F = '0; bus_a.P = '0;
        bus_b.clr = 1'b0; bus_b.in_valid = 1'b0; bus_b.F = '0; bus_b.P = '0;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_sum", bus_a.sum, 0);
        checkOutput("rst_out_valid", bus_a.out_valid, 0);
        checkOutput("rst_ovf", bus_a.ovf, 0);
        checkOutput("rst_b_sum", bus_b.sum, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", bus_a.in_ready, 1);
        checkOutput("rst_b_in_ready", bus_b.in_ready, 1);
        @(posedge clk);
        #1;

        // Single-sample blocks: value and accept-to-result latency
        for (int i = 0; i < 10; i++) begin
            bus_b.F = vecs[i].f;
            bus_b.P = vecs[i].p;
            bus_b.in_valid = 1'b1;
            @(negedge clk);
            checkOutput("b_ready", bus_b.in_ready, 1);
            @(posedge clk);
            #1;
            bus_b.in_valid = 1'b0;
            lat = -1;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (bus_b.out_valid) begin
                    lat = k;
                    break;
                end
            end
            checkOutput("b_latency", lat, vecs[i].exp_lat);
            checkOutput("b_sum", bus_b.sum, vecs[i].exp_sum);
            checkOutput("b_ovf", bus_b.ovf, 0);
            @(negedge clk);
            checkOutput("b_pulse_len", bus_b.out_valid, 0);
            @(posedge clk);
            #1;
        end

        // Eight samples of 10: overflow on the seventh add
        block_a(4'b1010, 2'd3, 8);
        wait_obs("blk10", SAT ? 63 : 16, 1);
        @(negedge clk);
        checkOutput("ovf_cleared", bus_a.ovf, 0);
        @(posedge clk);
        #1;

        // Mixed exponents plus zero samples, checking busy time per sample
        for (int i = 0; i < 8; i++) begin
            send_a(mix[i].f, mix[i].p, low);
            checkOutput("busy_cycles", low, 1 + (3 - int'(mix[i].p)) + ((i == 7) ? 1 : 0));
        end
        wait_obs("mixed", 16, 0);

        // Abort while the fourth sample is shifting
        block_a(4'b1000, 2'd2, 3);
        applyStimulus(4'b1000, 2'd0);
        bus_a.clr = 1'b1;
        @(negedge clk);
        checkOutput("clr_ready_low", bus_a.in_ready, 0);
        @(posedge clk);
        #1;
        bus_a.clr = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("clr_no_out", obs_q.size(), 0);
        checkOutput("clr_sum_hold", bus_a.sum, 16);
        @(posedge clk);
        #1;
        block_a(4'b1000, 2'd2, 8);
        wait_obs("after_clr", 32, 0);

        // Abort coincident with a held in_valid in IDLE
        bus_a.F = 4'b1100;
        bus_a.P = 2'd3;
        bus_a.in_valid = 1'b1;
        bus_a.clr = 1'b1;
        @(negedge clk);
        checkOutput("clr_beats_valid", bus_a.in_ready, 0);
        @(posedge clk);
        #1;
        bus_a.clr = 1'b0;
        @(negedge clk);
        checkOutput("clr_not_accepted", bus_a.in_ready, 1);
        accepts = 1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 100 && accepts < 8; k++) begin
            @(negedge clk);
            if (bus_a.in_ready) accepts++;
            @(posedge clk);
            #1;
        end
        bus_a.in_valid = 1'b0;
        checkOutput("held_accepts", accepts, 8);
        wait_obs("held", SAT ? 63 : 32, 1);

        // Asynchronous reset in the middle of a shifting sample
        block_a(4'b1111, 2'd3, 5);
        @(negedge clk);
        checkOutput("ovf_before_rst", bus_a.ovf, 1);
        @(posedge clk);
        #1;
        applyStimulus(4'b1000, 2'd0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("arst_sum", bus_a.sum, 0);
        checkOutput("arst_ovf", bus_a.ovf, 0);
        checkOutput("arst_out_valid", bus_a.out_valid, 0);
        checkOutput("arst_in_ready", bus_a.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("arst_no_out", obs_q.size(), 0);
        @(posedge clk);
        #1;
        block_a(4'b1000, 2'd3, 8);
        wait_obs("after_rst", SAT ? 63 : 0, 1);

        // Randomized traffic against the block-sum model
        obs_q.delete();
        cnt_m = 0;
        sum_m = 0;
        repeat (900) begin
            @(posedge clk);
            #1;
            do_clr = (cnt_m >= 1) && (cnt_m <= 7) && ($urandom_range(0, 24) == 0);
            bus_a.clr = do_clr;
            bus_a.in_valid = ($urandom_range(0, 3) != 0);
            bus_a.F = 4'($urandom);
            bus_a.P = 2'($urandom);
            @(negedge clk);
            if (do_clr) begin
                checkOutput("rand_clr_ready", bus_a.in_ready, 0);
                cnt_m = 0;
                sum_m = 0;
            end else if (bus_a.in_valid && bus_a.in_ready) begin
                sum_m += int'(bus_a.F) >> (3 - int'(bus_a.P));
                cnt_m++;
                if (cnt_m == 8) begin
                    exp_q.push_back(model_block(sum_m));
                    cnt_m = 0;
                    sum_m = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
        bus_a.clr = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("rand_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checkOutput("rand_sum", obs_q[i].s, exp_q[i].s);
            checkOutput("rand_ovf", obs_q[i].o, exp_q[i].o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/float_accumulator.md
FLOAT_ACCUMULATOR -- requirements
Module: float_accumulator

Interface
REQ-001 Parameter SUM_W, default 6, accumulator and sum output width in bits.
REQ-002 Parameter ACC_LEN, default 8, number of accepted samples per block sum (range 1..15).
REQ-003 sysClk  input  1  rising-edge clock for all state.
REQ-004 sysRst  input  1  asynchronous active-low reset.
REQ-005 clr  input  1  synchronous abort: discard partial sum, return to IDLE.
REQ-006 F  input  4  normalized mantissa from the upstream fixed-to-float stage (F[3]=1, or F=0).
REQ-007 P  input  2  exponent; represented value = F >> (3-P).
REQ-008 in_valid  input  1  F/P valid this cycle.
REQ-009 in_ready  output  1  block can accept; transfer when in_valid && in_ready.
REQ-010 sum  output  SUM_W  last completed block sum, held until next completion.
REQ-011 out_valid  output  1  one-cycle pulse when sum updates.
REQ-012 ovf  output  1  sticky overflow flag for the current block.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, DONE; in_ready = (state==IDLE) && !clr.
REQ-014 On transfer in IDLE: buf<=F, shcnt<=3-P, go to SHIFT.
REQ-015 SHIFT with shcnt!=0: buf<=buf>>1 (zero fill), shcnt<=shcnt-1, stay.
REQ-016 SHIFT with shcnt==0: acc<=acc+buf (buf zero-extended to SUM_W), cnt<=cnt+1; go to DONE if cnt==ACC_LEN-1, else IDLE.
REQ-017 Add latency: the add takes effect on edge T+1+(3-P) after accept edge T; P=3 -> 1 cycle, P=0 -> 4 cycles.
REQ-018 DONE (one cycle): sum<=final acc, out_valid=1, acc<=0, cnt<=0, ovf cleared for next block after being presented with sum, go to IDLE.
REQ-019 ovf SHALL set when an add carries out of SUM_W bits; remains set until the DONE of that block.
REQ-020 F=0 SHALL be accepted, add 0, and count as a sample.
REQ-021 F with F[3]=0 and F!=0 SHALL be processed arithmetically as given, unchecked.
REQ-022 clr in any state: next state IDLE, acc/cnt/ovf/shcnt <=0, no out_valid; sum holds its value; clr beats simultaneous in_valid.
REQ-023 out_valid SHALL never assert in two consecutive cycles.

Reset
REQ-024 sysRst low: state IDLE, in_ready=1 after release, sum=0, out_valid=0, ovf=0, acc=0, cnt=0, buf=0, shcnt=0.
REQ-025 Reset mid-SHIFT SHALL discard the in-flight sample with no output.

Configuration
REQ-026 Macro FLOAT_ACC_SAT_EN defined: on overflow acc SHALL saturate at 2^SUM_W-1 and stay there for the block.
REQ-027 Macro undefined: acc SHALL wrap modulo 2^SUM_W; ovf behaviour identical in both builds.

Structure
REQ-028 Shared package float_pkg SHALL hold mantissa width (4), exponent width (2), and the FSM state encoding.
REQ-029 One sub-module float_denorm (buf/shcnt serial right-shifter with load, busy, done) is natural; the accumulator/FSM stays in the top.

Verification
REQ-030 Reset then 8 samples F=4'b1010,P=3 -> after 8th add, out_valid pulse, sum=6'd(8*10 mod 64)=16 wrapped or 63 saturated, ovf=1.
REQ-031 Single-sample latency: F=4'b1000,P=0 with ACC_LEN=1 -> value 1 added on edge T+4, out_valid at T+5, sum=1.
REQ-032 Mixed: (1010,P=2)=5,(1100,P=1)=3,(1000,P=3)=8, five F=0 -> sum=16, ovf=0, in_ready low exactly 1+(3-P) cycles per sample.
REQ-033 clr asserted during SHIFT of 4th sample -> no out_valid, previous sum unchanged, next block starts from acc=0, cnt=0.
REQ-034 sysRst pulsed low mid-block -> all outputs at reset values asynchronously; subsequent 8 samples of F=4'b1000,P=3 give sum=64 wrap (0) / 63 sat, ovf=1.
REQ-035 in_valid held high continuously with clr pulse coincident with IDLE -> that sample not accepted, in_ready=0 that cycle.
